// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the in-order issue queue: entry payload,
// physical-register tag and branch-mask sizing, plus entry update helpers.
package issue_queue_pkg;

  localparam int unsigned REGISTERS = 128;
  localparam int unsigned BR_TAGS   = 4;
  localparam int unsigned TW        = $clog2(REGISTERS);
  localparam int unsigned BRW       = (BR_TAGS > 1) ? $clog2(BR_TAGS) : 1;
  localparam int unsigned OPW       = 8;

  typedef struct packed {
    logic [OPW-1:0]     opcode;
    logic [TW-1:0]      rs1;
    logic [TW-1:0]      rs2;
    logic [TW-1:0]      rs3;
    logic               pending1;
    logic               pending2;
    logic               pending3;
    logic [BR_TAGS-1:0] br_mask;
  } issue_entry_t;

  // Clear pending bits selected by a wakeup mask (bit 0 = rs1).
  function automatic issue_entry_t wake_entry(input issue_entry_t e, input logic [2:0] clr);
    issue_entry_t r;
    r          = e;
    r.pending1 = e.pending1 & ~clr[0];
    r.pending2 = e.pending2 & ~clr[1];
    r.pending3 = e.pending3 & ~clr[2];
    return r;
  endfunction

  function automatic issue_entry_t drop_br(input issue_entry_t e, input logic [BRW-1:0] idx);
    issue_entry_t r;
    r              = e;
    r.br_mask[idx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/issue_queue_spec_cam.sv
// Wakeup CAM: matches one entry's three source tags against every writeback
// tag port and reports which operands were produced this cycle.
module iq_wakeup_cam
  import issue_queue_pkg::*;
#(
  parameter int unsigned SEARCH_PORTS = 4
) (
  input  logic [2:0][TW-1:0]           tags,
  input  logic [SEARCH_PORTS-1:0]      search_valid,
  input  logic [SEARCH_PORTS-1:0][TW-1:0] search_tags,
  output logic [2:0]                   clear
);

  always_comb begin
    clear = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned s = 0; s < SEARCH_PORTS; s++) begin
        if (search_valid[s] && (search_tags[s] == tags[k])) clear[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_spec.sv
// In-order multi-port issue queue with operand wakeup and branch-tag kill.
// Optional IQ_BYPASS_WAKEUP_EN lets same-cycle wakeups make an entry issuable.
module issue_queue_spec
  import issue_queue_pkg::*;
#(
  parameter int unsigned INPUT_PORTS      = 2,
  parameter int unsigned OUTPUT_PORTS     = 2,
  parameter int unsigned SEARCH_PORTS     = 4,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned EXTRA_DATA_WIDTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  output logic [INPUT_PORTS-1:0]                        ready_out,
  input  logic [INPUT_PORTS-1:0]                        valid_in,
  input  issue_entry_t [INPUT_PORTS-1:0]                data_in,
  input  logic [INPUT_PORTS-1:0][EXTRA_DATA_WIDTH-1:0]  extra_in,
  output logic [OUTPUT_PORTS-1:0]                       valid_out,
  input  logic [OUTPUT_PORTS-1:0]                       ready_in,
  output issue_entry_t [OUTPUT_PORTS-1:0]               data_out,
  output logic [OUTPUT_PORTS-1:0][EXTRA_DATA_WIDTH-1:0] extra_out,
  input  logic [SEARCH_PORTS-1:0]                       search_valid,
  input  logic [SEARCH_PORTS-1:0][TW-1:0]               search_tags,
  input  logic                                          br_resolve_valid,
  input  logic [BRW-1:0]                                br_resolve_idx,
  input  logic                                          br_mispredict,
  input  logic                                          flush
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]               head, tail;
  logic [CW-1:0]               count;
  logic [DEPTH-1:0]            occ;
  issue_entry_t                entries [DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0] extras  [DEPTH];

  issue_entry_t                ent_nxt   [DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0] extra_nxt [DEPTH];
  issue_entry_t                view      [DEPTH];
  logic [2:0]                  st_clr    [DEPTH];
  logic [2:0]                  in_clr    [INPUT_PORTS];
  logic [DEPTH-1:0]            occ_nxt, rdy, kill;
  logic                        mispred, resolve_ok;
  int unsigned                 push_cnt, pop_cnt, kill_cnt;

  // Pointer arithmetic wraps at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_sub(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + DEPTH - n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  for (genvar e = 0; e < DEPTH; e++) begin : g_st_cam
    iq_wakeup_cam #(.SEARCH_PORTS(SEARCH_PORTS)) u_cam (
      .tags        ({entries[e].rs3, entries[e].rs2, entries[e].rs1}),
      .search_valid(search_valid),
      .search_tags (search_tags),
      .clear       (st_clr[e])
    );
  end

  for (genvar i = 0; i < INPUT_PORTS; i++) begin : g_in_cam
    iq_wakeup_cam #(.SEARCH_PORTS(SEARCH_PORTS)) u_cam (
      .tags        ({data_in[i].rs3, data_in[i].rs2, data_in[i].rs1}),
      .search_valid(search_valid),
      .search_tags (search_tags),
      .clear       (in_clr[i])
    );
  end

  // Per-entry readiness and mispredict kill.
  always_comb begin
    mispred    = br_resolve_valid & br_mispredict;
    resolve_ok = br_resolve_valid & ~br_mispredict;
    kill_cnt   = 0;
    rdy        = '0;
    kill       = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
`ifdef IQ_BYPASS_WAKEUP_EN
      view[e] = wake_entry(entries[e], st_clr[e]);
`else
      view[e] = entries[e];
`endif
      rdy[e]   = occ[e] & ~(view[e].pending1 | view[e].pending2 | view[e].pending3);
      kill[e]  = mispred & occ[e] & entries[e].br_mask[br_resolve_idx];
      kill_cnt = kill_cnt + 32'(kill[e]);
    end
  end

  // Push acceptance and in-order issue window.
  always_comb begin
    logic          chain;
    logic          pchain;
    logic [PW-1:0] idx;
    ready_out = '0;
    valid_out = '0;
    data_out  = '0;
    extra_out = '0;
    push_cnt  = 0;
    pop_cnt   = 0;
    idx       = '0;
    chain     = 1'b1;
    for (int unsigned i = 0; i < INPUT_PORTS; i++) begin
      ready_out[i] = ~rst & ~flush & ~mispred & ((32'(DEPTH) - 32'(count)) > i);
      chain        = chain & valid_in[i] & ready_out[i];
      if (chain) push_cnt = push_cnt + 1;
    end
    chain  = 1'b1;
    pchain = 1'b1;
    for (int unsigned j = 0; j < OUTPUT_PORTS; j++) begin
      idx          = ptr_add(head, j);
      chain        = chain & rdy[idx] & ~kill[idx] & ~flush & ~rst;
      valid_out[j] = chain;
      pchain       = pchain & chain & ready_in[j];
      if (pchain) pop_cnt = pop_cnt + 1;
      if (!rst) begin
        data_out[j]  = view[idx];
        extra_out[j] = extras[idx];
      end
    end
  end

  // Next storage contents: wakeup, mask clearing, pops and pushes.
  always_comb begin
    logic [PW-1:0] pidx;
    pidx    = '0;
    occ_nxt = occ & ~kill;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      ent_nxt[e]   = wake_entry(entries[e], st_clr[e]);
      if (resolve_ok) ent_nxt[e] = drop_br(ent_nxt[e], br_resolve_idx);
      extra_nxt[e] = extras[e];
    end
    for (int unsigned j = 0; j < OUTPUT_PORTS; j++) begin
      if (j < pop_cnt) occ_nxt[ptr_add(head, j)] = 1'b0;
    end
    for (int unsigned i = 0; i < INPUT_PORTS; i++) begin
      if (i < push_cnt) begin
        pidx            = ptr_add(tail, i);
        ent_nxt[pidx]   = wake_entry(data_in[i], in_clr[i]);
        if (resolve_ok) ent_nxt[pidx] = drop_br(ent_nxt[pidx], br_resolve_idx);
        extra_nxt[pidx] = extra_in[i];
        occ_nxt[pidx]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
    end else begin
      head  <= ptr_add(head, pop_cnt);
      tail  <= mispred ? ptr_sub(tail, kill_cnt) : ptr_add(tail, push_cnt);
      count <= CW'(32'(count) + push_cnt - pop_cnt - kill_cnt);
      occ   <= occ_nxt;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      entries[e] <= ent_nxt[e];
      extras[e]  <= extra_nxt[e];
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (valid_in & (valid_in + INPUT_PORTS'(1))) == '0);
  assert property (@(posedge clk) disable iff (rst)
    (ready_in & (ready_in + OUTPUT_PORTS'(1))) == '0);

endmodule

// File: tb/tb_issue_queue_spec.sv
// Directed self-checking bench for issue_queue_spec (DEPTH=8, 2 push, 2 pop ports).
module tb_issue_queue_spec;
  import issue_queue_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           ready_out;
  logic [1:0]           valid_in;
  issue_entry_t [1:0]   data_in;
  logic [1:0][3:0]      extra_in;
  logic [1:0]           valid_out;
  logic [1:0]           ready_in;
  issue_entry_t [1:0]   data_out;
  logic [1:0][3:0]      extra_out;
  logic [3:0]           search_valid;
  logic [3:0][TW-1:0]   search_tags;
  logic                 br_resolve_valid;
  logic [BRW-1:0]       br_resolve_idx;
  logic                 br_mispredict;
  logic                 flush;

  int tests = 0;
  int fails = 0;

  issue_queue_spec dut (
    .clk(clk), .rst(rst), .ready_out(ready_out), .valid_in(valid_in),
    .data_in(data_in), .extra_in(extra_in), .valid_out(valid_out),
    .ready_in(ready_in), .data_out(data_out), .extra_out(extra_out),
    .search_valid(search_valid), .search_tags(search_tags),
    .br_resolve_valid(br_resolve_valid), .br_resolve_idx(br_resolve_idx),
    .br_mispredict(br_mispredict), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic issue_entry_t mk(input logic [7:0] op, input logic [TW-1:0] r1,
                                      input logic [TW-1:0] r2, input logic [TW-1:0] r3,
                                      input logic [2:0] pend, input logic [3:0] mask);
    issue_entry_t e;
    e.opcode   = op;
    e.rs1      = r1;
    e.rs2      = r2;
    e.rs3      = r3;
    e.pending1 = pend[0];
    e.pending2 = pend[1];
    e.pending3 = pend[2];
    e.br_mask  = mask;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in         = '0;
    ready_in         = '0;
    search_valid     = '0;
    br_resolve_valid = 1'b0;
    br_mispredict    = 1'b0;
    br_resolve_idx   = '0;
    flush            = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    data_in     = '0;
    extra_in    = '0;
    search_tags = '0;
    idle();
    tick();
    chk("rst_ready", 64'(ready_out), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_data", 64'(data_out[0]), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("init_count", 64'(dut.count), 64'd0);
    chk("init_ready", 64'(ready_out), 64'b11);
    chk("init_valid", 64'(valid_out), 64'b00);

    // Two ready entries, popped together the following cycle.
    data_in[0] = mk(8'h10, 7'd1, 7'd2, 7'd3, 3'b000, 4'b0000);
    data_in[1] = mk(8'h11, 7'd4, 7'd5, 7'd6, 3'b000, 4'b0000);
    extra_in[0] = 4'hA;
    extra_in[1] = 4'h5;
    valid_in = 2'b11;
    #1;
    chk("t1_valid_empty", 64'(valid_out), 64'b00);
    tick();
    valid_in = 2'b00;
    ready_in = 2'b11;
    #1;
    chk("t1_valid", 64'(valid_out), 64'b11);
    chk("t1_op0", 64'(data_out[0].opcode), 64'h10);
    chk("t1_op1", 64'(data_out[1].opcode), 64'h11);
    chk("t1_extra0", 64'(extra_out[0]), 64'hA);
    chk("t1_extra1", 64'(extra_out[1]), 64'h5);
    chk("t1_count", 64'(dut.count), 64'd2);
    tick();
    ready_in = 2'b00;
    #1;
    chk("t1_count_after", 64'(dut.count), 64'd0);
    chk("t1_valid_after", 64'(valid_out), 64'b00);

    // Fill to DEPTH from tail=2, wrapping past slot 7.
    for (int k = 0; k < 4; k++) begin
      data_in[0] = mk(8'(8'h20 + 2 * k), 7'd0, 7'd0, 7'd0, 3'b000, 4'b0000);
      data_in[1] = mk(8'(8'h21 + 2 * k), 7'd0, 7'd0, 7'd0, 3'b000, 4'b0000);
      valid_in = 2'b11;
      #1;
      chk("fill_ready", 64'(ready_out), 64'b11);
      tick();
      valid_in = 2'b00;
      #1;
      chk("fill_tail", 64'(dut.tail), 64'((2 + 2 * (k + 1)) % 8));
    end
    chk("full_count", 64'(dut.count), 64'd8);
    chk("full_ready", 64'(ready_out), 64'b00);
    chk("full_valid", 64'(valid_out), 64'b11);
    ready_in = 2'b01;
    tick();
    ready_in = 2'b00;
    #1;
    chk("pop1_count", 64'(dut.count), 64'd7);
    chk("pop1_ready", 64'(ready_out), 64'b01);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", 64'(data_out[0].opcode), 64'(8'h21 + 2 * k));
      ready_in = 2'b11;
      tick();
    end
    ready_in = 2'b00;
    #1;
    chk("drain_count", 64'(dut.count), 64'd0);

    // Stored-entry wakeup of rs1=5.
    data_in[0] = mk(8'h30, 7'd5, 7'd0, 7'd0, 3'b001, 4'b0000);
    valid_in = 2'b01;
    tick();
    valid_in = 2'b00;
    search_valid = 4'b0010;
    search_tags[1] = 7'd6;
    #1;
    chk("wake_t1_valid", 64'(valid_out), 64'b00);
    chk("wake_t1_pend", 64'(data_out[0].pending1), 64'd1);
    tick();
    search_valid = 4'b0001;
    search_tags[0] = 7'd5;
    #1;
`ifdef IQ_BYPASS_WAKEUP_EN
    chk("wake_t2_valid", 64'(valid_out), 64'b01);
    chk("wake_t2_pend", 64'(data_out[0].pending1), 64'd0);
`else
    chk("wake_t2_valid", 64'(valid_out), 64'b00);
    chk("wake_t2_pend", 64'(data_out[0].pending1), 64'd1);
`endif
    tick();
    search_valid = 4'b0000;
    #1;
    chk("wake_t3_valid", 64'(valid_out), 64'b01);
    chk("wake_t3_pend", 64'(data_out[0].pending1), 64'd0);
    ready_in = 2'b01;
    tick();
    ready_in = 2'b00;

    // Push-time wakeup of rs2=9.
    data_in[0] = mk(8'h31, 7'd0, 7'd9, 7'd0, 3'b010, 4'b0000);
    valid_in = 2'b01;
    search_valid = 4'b0100;
    search_tags[2] = 7'd9;
    tick();
    valid_in = 2'b00;
    search_valid = 4'b0000;
    #1;
    chk("pushwake_valid", 64'(valid_out), 64'b01);
    chk("pushwake_pend", 64'(data_out[0].pending2), 64'd0);
    ready_in = 2'b01;
    tick();
    ready_in = 2'b00;

    // Mispredict idx=1 kills B and C, A survives.
    data_in[0] = mk(8'h40, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0000);
    data_in[1] = mk(8'h41, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0010);
    valid_in = 2'b11;
    tick();
    data_in[0] = mk(8'h42, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0010);
    valid_in = 2'b01;
    tick();
    valid_in = 2'b00;
    #1;
    chk("mp_count_pre", 64'(dut.count), 64'd3);
    chk("mp_valid_pre", 64'(valid_out), 64'b11);
    br_resolve_valid = 1'b1;
    br_mispredict = 1'b1;
    br_resolve_idx = 2'd1;
    #1;
    chk("mp_valid_same", 64'(valid_out), 64'b01);
    chk("mp_ready_same", 64'(ready_out), 64'b00);
    tick();
    idle();
    #1;
    chk("mp_count", 64'(dut.count), 64'd1);
    chk("mp_tail", 64'(dut.tail), 64'd5);
    chk("mp_valid", 64'(valid_out), 64'b01);
    chk("mp_survivor", 64'(data_out[0].opcode), 64'h40);
    ready_in = 2'b01;
    tick();
    ready_in = 2'b00;

    // Correct resolve idx=1 with a simultaneous push.
    data_in[0] = mk(8'h50, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0011);
    valid_in = 2'b01;
    tick();
    data_in[0] = mk(8'h51, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0010);
    valid_in = 2'b01;
    br_resolve_valid = 1'b1;
    br_mispredict = 1'b0;
    br_resolve_idx = 2'd1;
    #1;
    chk("res_ready", 64'(ready_out), 64'b11);
    tick();
    idle();
    #1;
    chk("res_count", 64'(dut.count), 64'd2);
    chk("res_mask0", 64'(data_out[0].br_mask), 64'b0001);
    chk("res_mask1", 64'(data_out[1].br_mask), 64'b0000);
    chk("res_valid", 64'(valid_out), 64'b11);

    // Flush beats push, pop and mispredict.
    data_in[0] = mk(8'h60, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0001);
    data_in[1] = mk(8'h61, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0001);
    valid_in = 2'b11;
    ready_in = 2'b11;
    br_resolve_valid = 1'b1;
    br_mispredict = 1'b1;
    br_resolve_idx = 2'd0;
    flush = 1'b1;
    #1;
    chk("flush_valid_same", 64'(valid_out), 64'b00);
    chk("flush_ready_same", 64'(ready_out), 64'b00);
    tick();
    idle();
    #1;
    chk("flush_count", 64'(dut.count), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'b00);
    chk("flush_ready", 64'(ready_out), 64'b11);

    // Reset mid-operation discards contents.
    data_in[0] = mk(8'h70, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0000);
    data_in[1] = mk(8'h71, 7'd0, 7'd0, 7'd0, 3'b000, 4'b0000);
    valid_in = 2'b11;
    tick();
    valid_in = 2'b00;
    #1;
    chk("mid_valid", 64'(valid_out), 64'b11);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(valid_out), 64'b00);
    chk("midrst_ready", 64'(ready_out), 64'b00);
    chk("midrst_data", 64'(data_out[0]), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_count", 64'(dut.count), 64'd0);
    chk("postrst_valid", 64'(valid_out), 64'b00);
    chk("postrst_ready", 64'(ready_out), 64'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
